// File: rtl/stop_watch_ctrl.sv
// Front-panel controller for stop_watch: button sync/debounce, run/pause/lap/clear FSM,
// lap snapshot display and countdown alarm.
module stop_watch_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic       btn_dir,
  input  logic [3:0] sw_d3,
  input  logic [3:0] sw_d2,
  input  logic [3:0] sw_d1,
  input  logic [3:0] sw_d0,
  input  logic       sw_minus,
  output logic       sw_set,
  output logic       sw_pause,
  output logic       sw_up,
  output logic [3:0] disp_d3,
  output logic [3:0] disp_d2,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d0,
  output logic       disp_minus,
  output logic       alarm,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    LAP    = 2'b11
  } state_t;

  localparam int unsigned B_START = 0;
  localparam int unsigned B_LAP   = 1;
  localparam int unsigned B_CLEAR = 2;
  localparam int unsigned B_DIR   = 3;

  logic [3:0]      raw;
  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      level;
  logic [3:0]      level_d;
  logic [3:0]      press;
  logic [DB_W-1:0] db_cnt [4];

  assign raw = {btn_dir, btn_clear, btn_lap, btn_start};

  // Accepted level flips on the DB_CYCLES-th consecutive synced sample that disagrees with it;
  // the press pulse is registered off the accepted rising edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  state_t      state_q;
  state_t      state_d;
  logic        set_q;
  logic        set_d;
  logic        up_q;
  logic        up_d;
  logic        alarm_q;
  logic        alarm_d;
  logic        minus_q;
  logic [16:0] disp_q;
  logic [16:0] disp_d;
  logic [16:0] live;
  logic        ev_clear;
  logic        ev_start;
  logic        ev_lap;
  logic        capture;
  logic        minus_rise;

  assign live       = {sw_d3, sw_d2, sw_d1, sw_d0, sw_minus};
  assign ev_clear   = press[B_CLEAR];
  assign ev_start   = press[B_START] & ~press[B_CLEAR];
  assign ev_lap     = press[B_LAP] & ~press[B_START] & ~press[B_CLEAR];
  assign minus_rise = sw_minus & ~minus_q;

  always_comb begin
    state_d = state_q;
    set_d   = 1'b0;
    capture = 1'b0;
    up_d    = up_q ^ press[B_DIR];
    alarm_d = alarm_q;

    case (state_q)
      IDLE: begin
        if (ev_start) begin
          state_d = RUN;
        end else if (ev_clear) begin
          set_d = 1'b1;
        end
      end
      RUN: begin
        if (ev_start) begin
          state_d = PAUSED;
        end else if (ev_lap) begin
          state_d = LAP;
          capture = 1'b1;
        end
      end
      PAUSED: begin
        if (ev_start) begin
          state_d = RUN;
        end else if (ev_clear) begin
          state_d = IDLE;
          set_d   = 1'b1;
        end
      end
      LAP: begin
        if (ev_lap) begin
          state_d = RUN;
        end else if (ev_start) begin
          state_d = PAUSED;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ev_start || ev_clear) begin
      alarm_d = 1'b0;
    end else if (minus_rise && !up_q && (state_q == RUN || state_q == LAP)) begin
      alarm_d = 1'b1;
    end

    // The display register doubles as the lap snapshot: loaded on entry, held while in LAP.
    if (state_d == LAP) begin
      disp_d = capture ? live : disp_q;
    end else begin
      disp_d = live;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      set_q   <= 1'b0;
      up_q    <= 1'b1;
      alarm_q <= 1'b0;
      minus_q <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      up_q    <= up_d;
      alarm_q <= alarm_d;
      minus_q <= sw_minus;
      disp_q  <= disp_d;
    end
  end

  assign state    = state_q;
  assign sw_set   = set_q;
  assign sw_up    = up_q;
  assign alarm    = alarm_q;
  assign sw_pause = (state_q == IDLE) || (state_q == PAUSED);
  assign {disp_d3, disp_d2, disp_d1, disp_d0, disp_minus} = disp_q;

endmodule
